// File: rtl/soc_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_slave_arbiter
// Purpose  : Transaction-level arbiter that shares one interconnect slave
//            port between three masters. Master 0 is high priority, masters
//            1 and 2 are served round-robin. A grant lasts from acceptance
//            until the slave's ready handshake. A bounded master-0 streak
//            keeps the low-priority masters from starving.
// Ports    : clk      - system clock, rising edge
//            res      - synchronous active-high reset
//            m_req    - per-master request, held until m_done/m_err
//            m_grant  - registered one-hot grant (0 when idle)
//            m_sel    - index of the granted master (0 when idle)
//            m_done   - one-hot completion pulse
//            m_err    - one-hot timeout-abort pulse
//            s_req    - request to the slave
//            s_ready  - slave completes the transaction when s_req=1
//            busy     - a transaction is in progress
// Options  : SOC_ARB_TIMEOUT_EN - enables the TIMEOUT_CYCLES abort timer
// Revision : 1.0 - initial release
// ============================================================================
module soc_slave_arbiter #(
    parameter int MAX_HI_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] m_req,
    output logic [2:0] m_grant,
    output logic [1:0] m_sel,
    output logic [2:0] m_done,
    output logic [2:0] m_err,
    output logic       s_req,
    input  logic       s_ready,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0]  c_max_streak   = 4'(MAX_HI_STREAK);
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_grant;
    logic [1:0] r_sel;
    logic       r_next_low;   // 0: master 1 preferred next, 1: master 2
    logic [3:0] r_hi_streak;

    state_t     w_state_nxt;
    logic [2:0] w_grant_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_next_low_nxt;
    logic [3:0] w_hi_streak_nxt;
    logic [1:0] w_win;

    logic w_low_req;
    logic w_hi_block;
    logic w_complete;
    logic w_timeout;

    assign busy       = (r_state == BUSY);
    assign s_req      = busy & m_req[r_sel];
    assign w_complete = s_req & s_ready;
    assign w_low_req  = m_req[1] | m_req[2];
    // Master 0 loses its priority once it has used up its streak while a
    // low-priority master is waiting.
    assign w_hi_block = (r_hi_streak == c_max_streak) && w_low_req;

    assign m_grant = r_grant;
    assign m_sel   = r_sel;
    assign m_done  = r_grant & {3{w_complete}};
    assign m_err   = r_grant & {3{w_timeout}};

`ifdef SOC_ARB_TIMEOUT_EN
    logic [15:0] r_timer;

    // Held at zero while idle, so it is zero in the first BUSY cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            r_timer <= 16'd0;
        end else if (r_state == IDLE) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // A completion in the timeout cycle takes precedence over the abort;
    // a withdrawn request (s_req low) never aborts.
    assign w_timeout = s_req && !s_ready && (r_timer == c_timeout_last);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^c_timeout_last;
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_sel_nxt       = r_sel;
        w_next_low_nxt  = r_next_low;
        w_hi_streak_nxt = r_hi_streak;
        w_win           = 2'd0;

        if (r_state == IDLE) begin
            if (m_req != 3'b000) begin
                if (m_req[0] && !w_hi_block) begin
                    w_win = 2'd0;
                    // Not blocked with a low request pending implies the
                    // streak is below the limit, so this saturates.
                    if (w_low_req) begin
                        w_hi_streak_nxt = r_hi_streak + 4'd1;
                    end
                end else if (m_req[1] && m_req[2]) begin
                    w_win           = r_next_low ? 2'd2 : 2'd1;
                    w_next_low_nxt  = ~r_next_low;
                    w_hi_streak_nxt = 4'd0;
                end else if (m_req[1]) begin
                    w_win           = 2'd1;
                    w_next_low_nxt  = 1'b1;
                    w_hi_streak_nxt = 4'd0;
                end else begin
                    w_win           = 2'd2;
                    w_next_low_nxt  = 1'b0;
                    w_hi_streak_nxt = 4'd0;
                end
                w_state_nxt = BUSY;
                w_grant_nxt = 3'b001 << w_win;
                w_sel_nxt   = w_win;
            end
        end else begin
            // Completion, abort or withdrawal all end the transaction.
            if (w_complete || !s_req || w_timeout) begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
                w_sel_nxt   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= IDLE;
            r_grant     <= 3'b000;
            r_sel       <= 2'd0;
            r_next_low  <= 1'b0;
            r_hi_streak <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_next_low  <= w_next_low_nxt;
            r_hi_streak <= w_hi_streak_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_slave_arbiter
// Purpose  : Self-checking bench for soc_slave_arbiter. A transaction-level
//            model tracks owner, age, round-robin preference and master-0
//            streak; every cycle the DUT outputs are compared with it.
//            Directed scenarios pin the model with literal expectations,
//            followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_slave_arbiter;

    localparam int MAX_HI = 4;
    localparam int TO     = 8;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [2:0] m_req = 3'b000;
    logic       s_ready = 1'b0;
    logic [2:0] m_grant;
    logic [1:0] m_sel;
    logic [2:0] m_done;
    logic [2:0] m_err;
    logic       s_req;
    logic       busy;

    int checks = 0;
    int errors = 0;

    soc_slave_arbiter #(
        .MAX_HI_STREAK (MAX_HI),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .res    (res),
        .m_req  (m_req),
        .m_grant(m_grant),
        .m_sel  (m_sel),
        .m_done (m_done),
        .m_err  (m_err),
        .s_req  (s_req),
        .s_ready(s_ready),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    bit         mdl_valid = 1'b0;
    bit         mdl_busy;
    int         mdl_owner;
    int         mdl_age;
    int         mdl_pref;     // low master (1 or 2) preferred on a tie
    int         mdl_streak;
    logic [2:0] exp_done = 3'b000;
    logic [2:0] exp_err  = 3'b000;

    always begin : p_compare
        logic [2:0] eg, ed, ee;
        logic [1:0] es;
        logic       esr;
        bit         lowp;
        @(negedge clk);
        eg = 3'b000; ed = 3'b000; ee = 3'b000; es = 2'd0; esr = 1'b0;
        if (mdl_valid) begin
            if (mdl_busy) begin
                eg  = 3'b001 << mdl_owner;
                es  = 2'(mdl_owner);
                esr = m_req[mdl_owner];
            end
            if (esr && s_ready) ed = eg;
`ifdef SOC_ARB_TIMEOUT_EN
            if (esr && !s_ready && mdl_age == TO - 1) ee = eg;
`endif
            chk("grant", 32'(m_grant), 32'(eg));
            chk("sel",   32'(m_sel),   32'(es));
            chk("busy",  32'(busy),    32'(mdl_busy));
            chk("s_req", 32'(s_req),   32'(esr));
            chk("done",  32'(m_done),  32'(ed));
            chk("err",   32'(m_err),   32'(ee));
        end
        exp_done = ed;
        exp_err  = ee;
        // State advance for the coming clock edge.
        if (res) begin
            mdl_valid  = 1'b1;
            mdl_busy   = 1'b0;
            mdl_owner  = 0;
            mdl_age    = 0;
            mdl_pref   = 1;
            mdl_streak = 0;
        end else if (mdl_valid) begin
            if (!mdl_busy) begin
                if (m_req != 3'b000) begin
                    lowp = m_req[1] || m_req[2];
                    if (m_req[0] && !(mdl_streak == MAX_HI && lowp)) begin
                        mdl_owner = 0;
                        if (lowp) mdl_streak = (mdl_streak + 1 > MAX_HI) ? MAX_HI : mdl_streak + 1;
                    end else begin
                        if (m_req[1] && m_req[2]) mdl_owner = mdl_pref;
                        else mdl_owner = m_req[1] ? 1 : 2;
                        mdl_pref   = 3 - mdl_owner;
                        mdl_streak = 0;
                    end
                    mdl_busy = 1'b1;
                    mdl_age  = 0;
                end
            end else if (!esr || ed != 3'b000 || ee != 3'b000) begin
                mdl_busy = 1'b0;
            end else begin
                mdl_age++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        res = 1'b1; m_req = 3'b000; s_ready = 1'b0;
        tick; tick;
        res = 1'b0;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [2:0] seq2 [8];
        logic [2:0] seq3 [10];
        logic [2:0] got3 [10];
        int         n3;
        int         busy_cnt;

        seq2 = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100};
        seq3 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

        // Reset state, combinational outputs quiet even with requests up.
        res = 1'b1; m_req = 3'b111; s_ready = 1'b1;
        tick; tick;
        @(negedge clk);
        chk("rst_grant", 32'(m_grant), 32'd0);
        chk("rst_sel",   32'(m_sel),   32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_sreq",  32'(s_req),   32'd0);
        chk("rst_done",  32'(m_done),  32'd0);

        // Single master-1 transaction with latency 1.
        do_reset;
        m_req = 3'b010;
        @(negedge clk); chk("t1_c0_grant", 32'(m_grant), 32'd0);
        tick; @(negedge clk);
        chk("t1_c1_grant", 32'(m_grant), 32'b010);
        chk("t1_c1_sel",   32'(m_sel),   32'd1);
        tick;
        tick; s_ready = 1'b1; @(negedge clk);
        chk("t1_c3_done",  32'(m_done),  32'b010);
        tick; s_ready = 1'b0; m_req = 3'b000; @(negedge clk);
        chk("t1_c4_grant", 32'(m_grant), 32'd0);
        chk("t1_c4_busy",  32'(busy),    32'd0);

        // Round-robin between the low masters.
        do_reset;
        m_req = 3'b110; s_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) tick;
            @(negedge clk);
            chk($sformatf("t2_rr_c%0d", c), 32'(m_grant), 32'(seq2[c]));
        end
        tick; m_req = 3'b000; s_ready = 1'b0; tick;

        // Master-0 streak limit.
        do_reset;
        m_req = 3'b111; s_ready = 1'b1;
        n3 = 0;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) tick;
            @(negedge clk);
            if (m_grant != 3'b000 && n3 < 10) begin
                got3[n3] = m_grant;
                n3++;
            end
        end
        chk("t3_count", 32'(n3), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < n3) chk($sformatf("t3_g%0d", i), 32'(got3[i]), 32'(seq3[i]));
        end
        tick; m_req = 3'b000; s_ready = 1'b0; tick;

        // Master 0 arrives mid-transaction.
        do_reset;
        m_req = 3'b010;
        tick;
        tick; m_req = 3'b011; @(negedge clk);
        chk("t4_c2_grant", 32'(m_grant), 32'b010);
        tick; @(negedge clk);
        chk("t4_c3_grant", 32'(m_grant), 32'b010);
        tick; s_ready = 1'b1; @(negedge clk);
        chk("t4_c4_done",  32'(m_done),  32'b010);
        tick; s_ready = 1'b0; m_req = 3'b001; @(negedge clk);
        chk("t4_c5_bubble", 32'(m_grant), 32'd0);
        tick; s_ready = 1'b1; @(negedge clk);
        chk("t4_c6_grant", 32'(m_grant), 32'b001);
        tick; s_ready = 1'b0; m_req = 3'b000; tick;

        // Withdrawal by master 2.
        do_reset;
        m_req = 3'b100;
        tick; @(negedge clk);
        chk("t5_c1_grant", 32'(m_grant), 32'b100);
        tick;
        tick; m_req = 3'b000; @(negedge clk);
        chk("t5_c3_sreq", 32'(s_req),  32'd0);
        chk("t5_c3_done", 32'(m_done), 32'd0);
        chk("t5_c3_err",  32'(m_err),  32'd0);
        tick; @(negedge clk);
        chk("t5_c4_busy", 32'(busy),   32'd0);

`ifdef SOC_ARB_TIMEOUT_EN
        // Abort after TO busy cycles, then completion winning the tie.
        for (int rep = 0; rep < 2; rep++) begin
            do_reset;
            m_req = 3'b010;
            for (int c = 1; c <= TO; c++) begin
                tick;
                if (c == TO && rep == 1) s_ready = 1'b1;
                @(negedge clk);
                if (c < TO) chk($sformatf("t6_r%0d_c%0d_err", rep, c), 32'(m_err), 32'd0);
            end
            chk($sformatf("t6_r%0d_err", rep),  32'(m_err),  rep == 0 ? 32'b010 : 32'd0);
            chk($sformatf("t6_r%0d_done", rep), 32'(m_done), rep == 0 ? 32'd0 : 32'b010);
            tick; s_ready = 1'b0; m_req = 3'b000; @(negedge clk);
            chk($sformatf("t6_r%0d_idle", rep), 32'(busy), 32'd0);
        end
`else
        // Without the timer a stalled transaction is held indefinitely.
        do_reset;
        m_req = 3'b010;
        busy_cnt = 0;
        for (int c = 1; c <= 110; c++) begin
            tick; @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("t6_no_timeout", 32'(busy_cnt), 32'd110);
        chk("t6_no_err",     32'(m_err),    32'd0);
        tick; s_ready = 1'b1;
        tick; s_ready = 1'b0; m_req = 3'b000;
`endif

        // Randomized traffic.
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            tick;
            res = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 3; m++) begin
                if (m_req[m]) begin
                    if (exp_done[m] || exp_err[m]) m_req[m] = 1'b0;
                    else if ($urandom_range(0, 59) == 0) m_req[m] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_req[m] = 1'b1;
                end
            end
            s_ready = ($urandom_range(0, 3) == 0);
        end
        tick; res = 1'b0; m_req = 3'b000; s_ready = 1'b0;
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
